// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants for the CNN datapath: pixel width, conv2
//                kernel size, pooled layer-1 map size and window count.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int CNN_DATA_W = 12;
  localparam int CONV2_K    = 5;
  localparam int POOL1_W    = 12;
  localparam int POOL1_H    = 12;

  // Number of complete KxK windows inside a w x h map (no padding).
  function automatic int conv_windows(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

  localparam int CONV2_WINDOWS = conv_windows(POOL1_W, POOL1_H, CONV2_K);

endpackage
`default_nettype wire

// File: rtl/conv2_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_buf_if
//  Description : Pixel-in / window-out bus of the conv2 line buffer.
//                master = pixel source, slave = window generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv2_buf_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int K      = CONV2_K
);

  logic                    valid_in;
  logic [DATA_W-1:0]       data_in;
  logic [K*K*DATA_W-1:0]   window_out;
  logic                    valid_out_buf;
  logic                    frame_done;

  modport master (
    output valid_in,
    output data_in,
    input  window_out,
    input  valid_out_buf,
    input  frame_done
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output window_out,
    output valid_out_buf,
    output frame_done
  );

endinterface
`default_nettype wire

// File: rtl/conv2_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_cnt
//  Description : Raster column/row counters for the conv2 window generator,
//                with registered window-valid and frame-end decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_cnt
  import cnn_pkg::*;
#(
  parameter int WIDTH  = POOL1_W,
  parameter int HEIGHT = POOL1_H,
  parameter int K      = CONV2_K
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic valid_in,
  output logic      win_valid,
  output logic      frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] C_COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] C_COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] C_ROW_MIN  = RW'(K - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_win_pos;

  // Position decode of the pixel currently presented on the input.
  always_comb begin
    w_col_last = (r_col == C_COL_LAST);
    w_row_last = (r_row == C_ROW_LAST);
    w_win_pos  = (r_col >= C_COL_MIN) && (r_row >= C_ROW_MIN);
  end

  // Advance on accepted pixels only; flag pulses one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= valid_in & w_win_pos;
      frame_done <= valid_in & w_col_last & w_row_last;
      if (valid_in) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2_buf.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_buf
//  Description : Sliding KxK window generator for conv2. A raster pixel
//                stream fills a (K-1)*WIDTH+K shift register; the K*K taps
//                are presented in parallel with a one-cycle valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_buf
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int WIDTH  = POOL1_W,
  parameter int HEIGHT = POOL1_H,
  parameter int K      = CONV2_K
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  conv2_buf_if.slave  bus
);

  localparam int DEPTH = (K - 1) * WIDTH + K;

  logic [DATA_W-1:0]     r_sr [DEPTH];
  logic [K*K*DATA_W-1:0] w_window;
  logic                  w_win_valid;
  logic                  w_frame_done;

  // Shift one entry per accepted pixel; newest pixel lands in entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else if (bus.valid_in) begin
      r_sr[0] <= bus.data_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  // Tap r*K+c (top-down, left-right) reads entry (K-1-r)*WIDTH + (K-1-c).
  always_comb begin
    w_window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_window[(r*K+c)*DATA_W +: DATA_W] = r_sr[(K-1-r)*WIDTH + (K-1-c)];
      end
    end
  end

  conv2_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .K      (K)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (bus.valid_in),
    .win_valid  (w_win_valid),
    .frame_done (w_frame_done)
  );

  assign bus.window_out    = w_window;
  assign bus.valid_out_buf = w_win_valid;
  assign bus.frame_done    = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv2_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv2_buf
//  Description : Directed self-checking bench for conv2_buf with a pixel
//                position model and pulse scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_buf;

  localparam int DW = 12;
  localparam int K  = 5;
  localparam int W  = 12;
  localparam int H  = 12;
  localparam int WW = K * K * DW;

  typedef struct {
    int          cyc;
    logic [WW-1:0] win;
    logic        fd;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  conv2_buf_if #(.DATA_W(DW), .K(K)) bus ();

  conv2_buf #(
    .DATA_W (DW),
    .WIDTH  (W),
    .HEIGHT (H),
    .K      (K)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge counter; read #1 after an edge it equals that edge's number.
  always @(posedge clk) cyc <= cyc + 1;

  int   checks   = 0;
  int   failures = 0;
  int   fd_cnt   = 0;
  rec_t act[$];
  rec_t exp_q[$];
  int   img [W*H];
  int   pr = 0;
  int   pc = 0;

  // Record every observed pulse and every frame_done.
  always @(negedge clk) begin
    rec_t r;
    if (bus.valid_out_buf === 1'b1) begin
      r.cyc = cyc;
      r.win = bus.window_out;
      r.fd  = bus.frame_done;
      act.push_back(r);
    end
    if (bus.frame_done === 1'b1) fd_cnt = fd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [WW-1:0] obs,
                          input logic [WW-1:0] expv);
    checks = checks + 1;
    if (obs !== expv) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic signed [DW-1:0] tap(input logic [WW-1:0] w,
                                               input int n);
    return w[n*DW +: DW];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one pixel and, if it completes a window, queue the expected pulse.
  task automatic push_pix(input int v);
    rec_t e;
    bus.valid_in = 1'b1;
    bus.data_in  = DW'(v);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    img[pr*W + pc] = v;
    if (pr >= K-1 && pc >= K-1) begin
      e.cyc = cyc;
      e.win = '0;
      for (int rr = 0; rr < K; rr++)
        for (int cc = 0; cc < K; cc++)
          e.win[(rr*K+cc)*DW +: DW] = DW'(img[(pr-K+1+rr)*W + (pc-K+1+cc)]);
      e.fd = (pr == H-1) && (pc == W-1);
      exp_q.push_back(e);
    end
    if (pc == W-1) begin
      pc = 0;
      pr = (pr == H-1) ? 0 : pr + 1;
    end else begin
      pc = pc + 1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n        = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = DW'(70);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    bus.valid_in = 1'b0;
    rst_n        = 1'b1;
    pr = 0;
    pc = 0;
  endtask

  task automatic compare_sb(input string name);
    int n;
    check_eq($sformatf("%s_npulse", name), act.size(), exp_q.size());
    n = (act.size() < exp_q.size()) ? act.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_win%0d", name, i), act[i].win, exp_q[i].win);
      check_eq($sformatf("%s_lat%0d", name, i), act[i].cyc, exp_q[i].cyc);
      check_eq($sformatf("%s_fd%0d", name, i), act[i].fd, exp_q[i].fd);
    end
    act.delete();
    exp_q.delete();
  endtask

  logic [WW-1:0] w0;

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_valid", bus.valid_out_buf, 1'b0);
    check_eq("rst_fd", bus.frame_done, 1'b0);
    check_eq("rst_win", bus.window_out, '0);

    // Consecutive ramp frame.
    for (int i = 0; i < W*H; i++) push_pix(i);
    idle(2);
    check_eq("s1_count", act.size(), 64);
    if (act.size() >= 64) begin
      check_eq("s1_first_tap0", tap(act[0].win, 0), 0);
      check_eq("s1_first_tap4", tap(act[0].win, 4), 4);
      check_eq("s1_first_tap20", tap(act[0].win, 20), 48);
      check_eq("s1_first_tap24", tap(act[0].win, 24), 52);
      check_eq("s1_second_tap0", tap(act[1].win, 0), 1);
      check_eq("s1_gap5_6", act[5].cyc - act[4].cyc, 1);
      check_eq("s1_rowwrap_gap", act[8].cyc - act[7].cyc, 5);
      check_eq("s1_last_tap24", tap(act[63].win, 24), 143);
      check_eq("s1_last_fd", act[63].fd, 1'b1);
    end
    compare_sb("s1");
    check_eq("s1_fdcnt", fd_cnt, 1);

    // Ramp with valid_in on every 3rd cycle.
    for (int i = 0; i < W*H; i++) begin
      push_pix(i);
      idle(2);
    end
    check_eq("s3_count", act.size(), 64);
    compare_sb("s3");
    check_eq("s3_fdcnt", fd_cnt, 2);

    // Two frames back-to-back, second negative.
    for (int i = 0; i < W*H; i++) push_pix(i);
    for (int i = 0; i < W*H; i++) push_pix(-i);
    idle(2);
    check_eq("s4_count", act.size(), 128);
    if (act.size() >= 128) begin
      check_eq("s4_f2_tap0", tap(act[64].win, 0), 0);
      check_eq("s4_f2_tap24", tap(act[64].win, 24), -52);
      check_eq("s4_f2_tap4", tap(act[64].win, 4), -4);
    end
    compare_sb("s4");
    check_eq("s4_fdcnt", fd_cnt, 4);

    // Reset mid-frame at pixel 70, then a fresh ramp.
    for (int i = 0; i < 70; i++) push_pix(i);
    do_reset(1);
    check_eq("s5_rst_valid", bus.valid_out_buf, 1'b0);
    check_eq("s5_rst_win", bus.window_out, '0);
    check_eq("s5_rst_fdcnt", fd_cnt, 4);
    for (int i = 0; i < W*H; i++) push_pix(i);
    idle(2);
    compare_sb("s5");
    check_eq("s5_fdcnt", fd_cnt, 5);

    // 20-cycle input gap after pixel 60.
    for (int i = 0; i <= 60; i++) push_pix(i);
    w0 = bus.window_out;
    for (int g = 0; g < 20; g++) begin
      idle(1);
      check_eq($sformatf("s6_gap_win%0d", g), bus.window_out, w0);
      check_eq($sformatf("s6_gap_valid%0d", g), bus.valid_out_buf, 1'b0);
    end
    for (int i = 61; i < W*H; i++) push_pix(i);
    idle(2);
    compare_sb("s6");
    check_eq("s6_fdcnt", fd_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
